// File: rtl/dep_check_fwd.sv
// Dependency check and forwarding controller between decode and EX.
// Tracks the last DEPTH issued destinations, registers EX/DM controls and stalls on load-use.
module dep_check_fwd #(
  parameter int         REG_AW   = 5,
  parameter int         DEPTH    = 3,
  parameter logic [5:0] LOAD_OP  = 6'b010100,
  parameter logic [5:0] STORE_OP = 6'b010101,
  parameter int         CNT_W    = 16,
  localparam int        SEL_W    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       ins,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              ex_valid,
  output logic [5:0]        op_ex,
  output logic [15:0]       imm_ex,
  output logic [REG_AW-1:0] rw_ex,
  output logic [SEL_W-1:0]  mux_sel_A,
  output logic [SEL_W-1:0]  mux_sel_B,
  output logic [SEL_W-1:0]  mux_sel_S,
  output logic              imm_sel,
  output logic              mem_en_ex,
  output logic              mem_rw_ex,
  output logic [REG_AW-1:0] RW_dm,
  output logic              wr_en_dm,
  output logic              mem_mux_sel_dm,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic [5:0]        op_in;
  logic [REG_AW-1:0] rd_in;
  logic [REG_AW-1:0] rs1_in;
  logic [REG_AW-1:0] rs2_in;
  logic [15:0]       imm_in;
  logic              is_load_in;
  logic              is_store_in;
  logic              imm_sel_in;
  logic              wr_in;
  logic              use_rs2;
  logic              use_rd;

  assign op_in       = ins[31:26];
  assign rd_in       = ins[25:21];
  assign rs1_in      = ins[20:16];
  assign rs2_in      = ins[15:11];
  assign imm_in      = ins[15:0];
  assign is_load_in  = (op_in == LOAD_OP);
  assign is_store_in = (op_in == STORE_OP);
  assign imm_sel_in  = op_in[3] | is_load_in | is_store_in;
  assign wr_in       = !is_store_in && (rd_in != '0);
  assign use_rs2     = !imm_sel_in;
  assign use_rd      = is_store_in;

  // Tracking pipe: index 1 is EX, index 2 is DM, and so on.
  logic [DEPTH:1]    valid_q, valid_d;
  logic [DEPTH:1]    wr_q, wr_d;
  logic [DEPTH:1]    load_q, load_d;
  logic [REG_AW-1:0] dst_q [1:DEPTH];
  logic [REG_AW-1:0] dst_d [1:DEPTH];

  logic [5:0]        op_ex_q, op_ex_d;
  logic [15:0]       imm_ex_q, imm_ex_d;
  logic [SEL_W-1:0]  sel_a_q, sel_a_d;
  logic [SEL_W-1:0]  sel_b_q, sel_b_d;
  logic [SEL_W-1:0]  sel_s_q, sel_s_d;
  logic              imm_sel_q, imm_sel_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_rw_q, mem_rw_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

  logic [SEL_W-1:0]  match_a, match_b, match_s;
  logic              ex_is_load;
  logic              hazard;
  logic              accept;

  // Scan far-to-near so the nearest producer overwrites any older match.
  always_comb begin
    match_a = '0;
    match_b = '0;
    match_s = '0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (valid_q[k] && wr_q[k]) begin
        if (dst_q[k] == rs1_in)             match_a = SEL_W'(k);
        if (use_rs2 && (dst_q[k] == rs2_in)) match_b = SEL_W'(k);
        if (use_rd && (dst_q[k] == rd_in))   match_s = SEL_W'(k);
      end
    end
  end

  // A load targeting r0 never stalls: r0 is not a real dependency.
  assign ex_is_load = valid_q[1] & wr_q[1] & load_q[1];
  assign hazard     = in_valid && ex_is_load &&
                      ((dst_q[1] == rs1_in) ||
                       (use_rs2 && (dst_q[1] == rs2_in)) ||
                       (use_rd && (dst_q[1] == rd_in)));
  assign in_ready   = !hazard || flush;
  assign accept     = in_valid && !flush && !hazard;

  always_comb begin
    valid_d  = {valid_q[DEPTH-1:1], accept};
    wr_d     = {wr_q[DEPTH-1:1], accept & wr_in};
    load_d   = {load_q[DEPTH-1:1], accept & is_load_in};
    dst_d[1] = accept ? rd_in : '0;
    for (int k = 2; k <= DEPTH; k++) begin
      dst_d[k] = dst_q[k-1];
    end

    op_ex_d   = accept ? op_in : '0;
    imm_ex_d  = accept ? imm_in : '0;
    sel_a_d   = accept ? match_a : '0;
    sel_b_d   = accept ? match_b : '0;
    sel_s_d   = accept ? match_s : '0;
    imm_sel_d = accept & imm_sel_in;
    mem_en_d  = accept & (is_load_in | is_store_in);
    mem_rw_d  = accept & is_store_in;

    stall_cnt_d = stall_cnt_q;
    if (hazard && !flush && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
      wr_q    <= '0;
      load_q  <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        dst_q[k] <= '0;
      end
      op_ex_q     <= '0;
      imm_ex_q    <= '0;
      sel_a_q     <= '0;
      sel_b_q     <= '0;
      sel_s_q     <= '0;
      imm_sel_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_rw_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      valid_q <= valid_d;
      wr_q    <= wr_d;
      load_q  <= load_d;
      for (int k = 1; k <= DEPTH; k++) begin
        dst_q[k] <= dst_d[k];
      end
      op_ex_q     <= op_ex_d;
      imm_ex_q    <= imm_ex_d;
      sel_a_q     <= sel_a_d;
      sel_b_q     <= sel_b_d;
      sel_s_q     <= sel_s_d;
      imm_sel_q   <= imm_sel_d;
      mem_en_q    <= mem_en_d;
      mem_rw_q    <= mem_rw_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign ex_valid       = valid_q[1];
  assign op_ex          = op_ex_q;
  assign imm_ex         = imm_ex_q;
  assign rw_ex          = dst_q[1];
  assign mux_sel_A      = sel_a_q;
  assign mux_sel_B      = sel_b_q;
  assign mux_sel_S      = sel_s_q;
  assign imm_sel        = imm_sel_q;
  assign mem_en_ex      = mem_en_q;
  assign mem_rw_ex      = mem_rw_q;
  assign RW_dm          = dst_q[2];
  assign wr_en_dm       = wr_q[2];
  assign mem_mux_sel_dm = load_q[2];
  assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_dep_check_fwd.sv
// Self-checking bench for dep_check_fwd: directed scenarios plus randomized traffic
// checked against a history-queue reference model.
module tb_dep_check_fwd;

  localparam int         DEPTH    = 3;
  localparam logic [5:0] LOAD_OP  = 6'b010100;
  localparam logic [5:0] STORE_OP = 6'b010101;

  logic        clk;
  logic        reset;
  logic [31:0] ins;
  logic        in_valid;
  logic        in_ready;
  logic        flush;
  logic        ex_valid;
  logic [5:0]  op_ex;
  logic [15:0] imm_ex;
  logic [4:0]  rw_ex;
  logic [1:0]  mux_sel_A, mux_sel_B, mux_sel_S;
  logic        imm_sel, mem_en_ex, mem_rw_ex;
  logic [4:0]  RW_dm;
  logic        wr_en_dm, mem_mux_sel_dm;
  logic [15:0] stall_cnt;

  dep_check_fwd #(
    .REG_AW(5), .DEPTH(DEPTH), .LOAD_OP(LOAD_OP), .STORE_OP(STORE_OP), .CNT_W(16)
  ) dut (
    .clk(clk), .reset(reset), .ins(ins), .in_valid(in_valid), .in_ready(in_ready),
    .flush(flush), .ex_valid(ex_valid), .op_ex(op_ex), .imm_ex(imm_ex), .rw_ex(rw_ex),
    .mux_sel_A(mux_sel_A), .mux_sel_B(mux_sel_B), .mux_sel_S(mux_sel_S),
    .imm_sel(imm_sel), .mem_en_ex(mem_en_ex), .mem_rw_ex(mem_rw_ex), .RW_dm(RW_dm),
    .wr_en_dm(wr_en_dm), .mem_mux_sel_dm(mem_mux_sel_dm), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_total  = 0;
  int checks_passed = 0;

  typedef struct packed { logic v; logic [4:0] dst; logic wr; logic ld; } slot_t;
  slot_t       hist[$];
  logic [15:0] exp_cnt;
  logic        exp_ready;
  logic [59:0] exp_vec;
  logic        rdy_obs;

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2);
    return {op, rd, rs1, rs2, 11'h000};
  endfunction

  function automatic logic [59:0] obs_vec();
    return {ex_valid, op_ex, imm_ex, rw_ex, mux_sel_A, mux_sel_B, mux_sel_S, imm_sel,
            mem_en_ex, mem_rw_ex, RW_dm, wr_en_dm, mem_mux_sel_dm, stall_cnt};
  endfunction

  // Distance (1 = EX) of the youngest in-flight instruction writing src, 0 if none.
  function automatic int producer_distance(input logic [4:0] src);
    for (int k = 0; k < hist.size(); k++) begin
      if (hist[k].v && hist[k].wr && hist[k].dst == src) return k + 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    slot_t empty;
    empty = '0;
    hist.delete();
    for (int k = 0; k < DEPTH; k++) hist.push_back(empty);
    exp_cnt   = 16'h0;
    exp_ready = 1'b1;
    exp_vec   = '0;
  endtask

  task automatic model_step(input logic [31:0] i, input logic v, input logic f);
    logic [5:0] op;
    logic [4:0] rd, rs1, rs2;
    logic       ld, st, isel, hazard, acc;
    int         da, db, ds;
    slot_t      s;
    op = i[31:26]; rd = i[25:21]; rs1 = i[20:16]; rs2 = i[15:11];
    ld = (op == LOAD_OP);
    st = (op == STORE_OP);
    isel = op[3] | ld | st;
    da = producer_distance(rs1);
    db = isel ? 0 : producer_distance(rs2);
    ds = st ? producer_distance(rd) : 0;
    // a load still in EX cannot supply its result to a dependant
    hazard = v && hist[0].ld && (da == 1 || db == 1 || ds == 1);
    exp_ready = !hazard || f;
    acc = v && !f && !hazard;
    if (hazard && !f && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    s.v = acc; s.dst = acc ? rd : 5'd0; s.wr = acc && !st && rd != 0; s.ld = acc && ld;
    hist.push_front(s);
    void'(hist.pop_back());
    if (!acc) begin da = 0; db = 0; ds = 0; end
    exp_vec = {acc, acc ? op : 6'h0, acc ? i[15:0] : 16'h0, acc ? rd : 5'h0,
               2'(da), 2'(db), 2'(ds), acc & isel, acc & (ld | st), acc & st,
               hist[1].dst, hist[1].wr, hist[1].ld, exp_cnt};
  endtask

  task automatic drive(input logic [31:0] i, input logic v, input logic f);
    ins = i; in_valid = v; flush = f;
    #1;
    rdy_obs = in_ready;
    model_step(i, v, f);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    repeat (DEPTH + 1) drive(32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; ins = mk(LOAD_OP, 4, 1, 0); in_valid = 1'b1; flush = 1'b0;
    model_reset();
    #3;
    checks_total++;
    if (obs_vec() !== 60'h0) $display("[TB] FAIL reset_outputs got %h want 0", obs_vec());
    else checks_passed++;
    checks_total++;
    if (in_ready !== 1'b1) $display("[TB] FAIL reset_ready got %b want 1", in_ready);
    else checks_passed++;
    in_valid = 1'b0;
    reset = 1'b1;
    drive(32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_alu_fwd();
    drain();
    drive(32'h00221800, 1'b1, 1'b0);
    drive(32'h10A10800, 1'b1, 1'b0);
    checks_total++;
    if (rdy_obs !== 1'b1 || ex_valid !== 1'b1)
      $display("[TB] FAIL alu_issue got rdy=%b ex_valid=%b want 1/1", rdy_obs, ex_valid);
    else checks_passed++;
    checks_total++;
    if (mux_sel_A !== 2'd1 || mux_sel_B !== 2'd1)
      $display("[TB] FAIL alu_sel got A=%0d B=%0d want 1/1", mux_sel_A, mux_sel_B);
    else checks_passed++;
  endtask

  task automatic test_load_use();
    drain();
    drive(32'h50810000, 1'b1, 1'b0);
    drive(32'h00A41000, 1'b1, 1'b0);
    checks_total++;
    if (rdy_obs !== 1'b0 || ex_valid !== 1'b0)
      $display("[TB] FAIL lu_stall got rdy=%b ex_valid=%b want 0/0", rdy_obs, ex_valid);
    else checks_passed++;
    checks_total++;
    if (RW_dm !== 5'd4 || mem_mux_sel_dm !== 1'b1 || wr_en_dm !== 1'b1)
      $display("[TB] FAIL lu_dm got RW=%0d mux=%b wr=%b want 4/1/1", RW_dm, mem_mux_sel_dm, wr_en_dm);
    else checks_passed++;
    checks_total++;
    if (stall_cnt !== 16'd1) $display("[TB] FAIL lu_cnt got %0d want 1", stall_cnt);
    else checks_passed++;
    drive(32'h00A41000, 1'b1, 1'b0);
    checks_total++;
    if (rdy_obs !== 1'b1 || ex_valid !== 1'b1 || mux_sel_A !== 2'd2 || mux_sel_B !== 2'd0)
      $display("[TB] FAIL lu_issue got rdy=%b v=%b A=%0d B=%0d want 1/1/2/0",
               rdy_obs, ex_valid, mux_sel_A, mux_sel_B);
    else checks_passed++;
  endtask

  task automatic test_imm();
    drain();
    drive(32'h34C10005, 1'b1, 1'b0);
    checks_total++;
    if (imm_sel !== 1'b1 || imm_ex !== 16'h0005 || rw_ex !== 5'd6 || mux_sel_B !== 2'd0)
      $display("[TB] FAIL imm_form got isel=%b imm=%h rw=%0d B=%0d want 1/0005/6/0",
               imm_sel, imm_ex, rw_ex, mux_sel_B);
    else checks_passed++;
    drive(32'h00221800, 1'b1, 1'b0);
    drive(mk(6'b001101, 6, 1, 1), 1'b1, 1'b0);
    checks_total++;
    if (mux_sel_A !== 2'd1 || mux_sel_B !== 2'd0 || mem_en_ex !== 1'b0)
      $display("[TB] FAIL imm_rs2_ignored got A=%0d B=%0d men=%b want 1/0/0",
               mux_sel_A, mux_sel_B, mem_en_ex);
    else checks_passed++;
  endtask

  task automatic test_distance();
    drain();
    drive(mk(6'h0, 1, 2, 3), 1'b1, 1'b0);
    repeat (2) drive(mk(6'h0, 7, 2, 3), 1'b1, 1'b0);
    drive(mk(6'h0, 5, 1, 2), 1'b1, 1'b0);
    checks_total++;
    if (mux_sel_A !== 2'd3) $display("[TB] FAIL dist3 got %0d want 3", mux_sel_A);
    else checks_passed++;
    drain();
    drive(mk(6'h0, 1, 2, 3), 1'b1, 1'b0);
    repeat (3) drive(mk(6'h0, 7, 2, 3), 1'b1, 1'b0);
    drive(mk(6'h0, 5, 1, 2), 1'b1, 1'b0);
    checks_total++;
    if (mux_sel_A !== 2'd0) $display("[TB] FAIL dist4 got %0d want 0", mux_sel_A);
    else checks_passed++;
    drive(mk(6'h0, 0, 2, 3), 1'b1, 1'b0);
    drive(mk(6'h0, 5, 0, 0), 1'b1, 1'b0);
    checks_total++;
    if (mux_sel_A !== 2'd0 || mux_sel_B !== 2'd0)
      $display("[TB] FAIL r0_rule got A=%0d B=%0d want 0/0", mux_sel_A, mux_sel_B);
    else checks_passed++;
  endtask

  task automatic test_nearest();
    drain();
    drive(mk(6'h0, 1, 2, 3), 1'b1, 1'b0);
    drive(mk(6'h0, 1, 3, 2), 1'b1, 1'b0);
    drive(mk(6'h0, 5, 1, 2), 1'b1, 1'b0);
    checks_total++;
    if (mux_sel_A !== 2'd1) $display("[TB] FAIL nearest got %0d want 1", mux_sel_A);
    else checks_passed++;
  endtask

  task automatic test_flush();
    drain();
    drive(mk(LOAD_OP, 4, 2, 0), 1'b1, 1'b0);
    drive(mk(6'h0, 5, 4, 3), 1'b1, 1'b1);
    checks_total++;
    if (rdy_obs !== 1'b1 || ex_valid !== 1'b0 || stall_cnt !== 16'd1)
      $display("[TB] FAIL flush_stall got rdy=%b v=%b cnt=%0d want 1/0/1",
               rdy_obs, ex_valid, stall_cnt);
    else checks_passed++;
    drive(mk(6'h0, 5, 4, 3), 1'b1, 1'b0);
    checks_total++;
    if (rdy_obs !== 1'b1 || ex_valid !== 1'b1 || mux_sel_A !== 2'd2)
      $display("[TB] FAIL flush_after got rdy=%b v=%b A=%0d want 1/1/2",
               rdy_obs, ex_valid, mux_sel_A);
    else checks_passed++;
  endtask

  task automatic test_back_to_back();
    drain();
    drive(mk(LOAD_OP, 4, 2, 0), 1'b1, 1'b0);
    drive(mk(6'h0, 5, 4, 3), 1'b1, 1'b0);
    drive(mk(6'h0, 5, 4, 3), 1'b1, 1'b0);
    drive(mk(6'h0, 6, 4, 4), 1'b1, 1'b0);
    checks_total++;
    if (rdy_obs !== 1'b1 || mux_sel_A !== 2'd3 || mux_sel_B !== 2'd3 || stall_cnt !== 16'd2)
      $display("[TB] FAIL b2b got rdy=%b A=%0d B=%0d cnt=%0d want 1/3/3/2",
               rdy_obs, mux_sel_A, mux_sel_B, stall_cnt);
    else checks_passed++;
  endtask

  task automatic test_reset_mid();
    drain();
    drive(mk(6'h0, 1, 2, 3), 1'b1, 1'b0);
    drive(mk(LOAD_OP, 4, 2, 0), 1'b1, 1'b0);
    ins = mk(6'h0, 5, 4, 1); in_valid = 1'b1; flush = 1'b0;
    #1;
    checks_total++;
    if (in_ready !== 1'b0) $display("[TB] FAIL mid_stall got rdy=%b want 0", in_ready);
    else checks_passed++;
    reset = 1'b0;
    model_reset();
    #1;
    checks_total++;
    if (obs_vec() !== 60'h0 || in_ready !== 1'b1)
      $display("[TB] FAIL mid_reset got %h rdy=%b want 0/1", obs_vec(), in_ready);
    else checks_passed++;
    #1;
    reset = 1'b1;
    drive(mk(6'h0, 5, 4, 1), 1'b1, 1'b0);
    checks_total++;
    if (ex_valid !== 1'b1 || mux_sel_A !== 2'd0 || mux_sel_B !== 2'd0)
      $display("[TB] FAIL post_reset got v=%b A=%0d B=%0d want 1/0/0",
               ex_valid, mux_sel_A, mux_sel_B);
    else checks_passed++;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [5:0] op;
    case ($urandom_range(0, 4))
      0: op = 6'h00;
      1: op = 6'b000100;
      2: op = 6'b001101;
      3: op = LOAD_OP;
      default: op = STORE_OP;
    endcase
    return {op, 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            5'($urandom_range(0, 3)), 11'($urandom)};
  endfunction

  task automatic test_random();
    logic [31:0] cur;
    logic        hold, v, f;
    hold = 1'b0;
    cur  = 32'h0;
    for (int n = 0; n < 400; n++) begin
      if (!hold) cur = rand_ins();
      v = hold ? 1'b1 : ($urandom_range(0, 9) < 8);
      f = ($urandom_range(0, 15) == 0);
      drive(cur, v, f);
      checks_total++;
      if (rdy_obs !== exp_ready)
        $display("[TB] FAIL rand_ready n=%0d got %b want %b", n, rdy_obs, exp_ready);
      else checks_passed++;
      checks_total++;
      if (obs_vec() !== exp_vec)
        $display("[TB] FAIL rand_outputs n=%0d got %h want %h", n, obs_vec(), exp_vec);
      else checks_passed++;
      hold = v && !exp_ready;
    end
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout got no finish want finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_imm();
    test_distance();
    test_nearest();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
